regfile_fwd_sb: RTL and testbench
=================================

# regfile_fwd_sb

Parametrised general-purpose register file for the pipelined core. It has NRD combinational read ports, one writeback port, and a two-source bypass network (MEM-stage forward and same-cycle writeback). A per-register scoreboard tracks in-flight writers and flags operands that are not yet available. It replaces the fixed 32x32, two-read-port register file in the decode stage.

## Interface
- DW, 32, data width in bits
- AW, 5, address width; depth = 2**AW
- NRD, 2, number of read ports
- ZERO_REG, 1, when 1 register 0 always reads 0 and is never written or scoreboarded

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- rd_addr  in  NRD*AW  read addresses; port p at [p*AW +: AW]
- rd_data  out  NRD*DW  read data; port p at [p*DW +: DW]
- rd_busy  out  NRD  port p operand pending and not bypassable
- wb_en  in  1  writeback enable
- wb_addr  in  AW  writeback address
- wb_data  in  DW  writeback data
- fwd_en  in  1  MEM-stage result valid for forwarding
- fwd_addr  in  AW  MEM-stage destination
- fwd_data  in  DW  MEM-stage result
- iss_en  in  1  instruction with a destination issues this cycle
- iss_addr  in  AW  destination of issuing instruction
- pend_cnt  out  AW+1  number of registers with pending bit set
- err_waw  out  1  sticky: issue to an already-pending register

## Operation
- Storage: 2**AW x DW array plus a 2**AW pending-bit vector.
- Read mux per port p (combinational), in priority order:
  1. ZERO_REG and addr==0 -> 0
  2. fwd_en and fwd_addr==addr -> fwd_data (younger stage wins)
  3. wb_en and wb_addr==addr -> wb_data
  4. otherwise array[addr]
- Bypass from the fwd and wb sources applies to address 0 only when ZERO_REG=0.
- rd_busy[p] = pending[addr] and not (fwd hit) and not (wb hit), and is 0 for addr 0 when ZERO_REG=1.
- Write: wb_en, and not (ZERO_REG and wb_addr==0) -> array[wb_addr] <= wb_data at the rising edge.
- Scoreboard, evaluated per rising edge:
  - wb_en clears pending[wb_addr].
  - iss_en sets pending[iss_addr].
  - iss and wb to the same address in the same cycle -> set wins; the bit stays 1.
  - iss_addr==0 with ZERO_REG=1 -> ignored.
- err_waw is set when iss_en, pending[iss_addr]=1, and no same-cycle wb clears that address. It is cleared only by reset. The pending bit stays 1.
- pend_cnt is the registered popcount of the pending vector after the update and equals the popcount at all times. It never exceeds 2**AW (width AW+1).
- One in-flight writer per register. The issue logic stalls on rd_busy or pending. The block only flags violations of this rule.

## Timing
- Reads: 0-cycle latency, purely combinational from rd_addr, fwd_*, wb_*, array, and pending.
- Writes and scoreboard updates: visible in the array and pending bits from the cycle after the edge. The same-cycle value is already visible through the wb bypass.
- Reset asserted at any time clears, immediately and without waiting for a clock edge:
  - every array entry to 0
  - all pending bits
  - pend_cnt = 0
  - err_waw = 0
- rd_data then reflects the zeros, or the bypass value when wb_en/fwd_en hit. rd_busy = 0 on all ports.
- Reset dominates: wb_en and iss_en on an edge while reset is high have no effect.
- Reset deassertion takes effect at the next rising edge. No state is held across reset mid-operation.

## Test plan
- Reset, then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, pend_cnt=0, err_waw=0.
- wb_en, addr 5, data 0xDEADBEEF while rd_addr[0]=5 -> same-cycle rd_data[0]=0xDEADBEEF; next cycle with wb_en=0 still 0xDEADBEEF. Write to addr 0 -> reads 0.
- Array[7]=0x11; same cycle wb 7<-0x22 and fwd 7<-0x33, port 1 reads 7 -> 0x33. Drop fwd_en -> 0x22.
- iss_en addr 9 -> next cycle pending set: rd_busy=1 on a port reading 9, pend_cnt=1. fwd 9 that cycle -> rd_busy=0, rd_data=fwd_data. wb 9 <- 0x44 -> following cycle rd_busy=0, pend_cnt=0, read 0x44.
- Register 3 pending; same-cycle iss 3 and wb 3 -> pending stays 1, err_waw=0. Then iss 3 again with no wb -> err_waw=1 and stays 1 until reset.
- Issue to regs 1..4 and write several values, then pulse reset between clock edges -> outputs zero immediately, pend_cnt=0, err_waw=0.

Source files
------------

// File: rtl/regfile_fwd_sb_if.sv
// Register file port bundle: read ports, writeback, MEM forward,
// issue scoreboard and status.
interface regfile_fwd_sb_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
);
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              fwd_en;
    logic [AW-1:0]     fwd_addr;
    logic [DW-1:0]     fwd_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic [AW:0]       pend_cnt;
    logic              err_waw;

    modport master (
        output rd_addr, wb_en, wb_addr, wb_data,
        output fwd_en, fwd_addr, fwd_data,
        output iss_en, iss_addr,
        input  rd_data, rd_busy, pend_cnt, err_waw
    );

    modport slave (
        input  rd_addr, wb_en, wb_addr, wb_data,
        input  fwd_en, fwd_addr, fwd_data,
        input  iss_en, iss_addr,
        output rd_data, rd_busy, pend_cnt, err_waw
    );
endinterface

// File: rtl/regfile_fwd_sb.sv
// General-purpose register file with MEM/WB bypass and a
// per-register scoreboard of in-flight writers.
module regfile_fwd_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    regfile_fwd_sb_if.slave   bus
);
    localparam int DEPTH = 1 << AW;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_nxt;
    logic             err_q;
    logic             wb_ok;
    logic             iss_ok;
    logic             waw_hit;

    assign wb_ok  = bus.wb_en  && !(ZR && bus.wb_addr  == '0);
    assign iss_ok = bus.iss_en && !(ZR && bus.iss_addr == '0);

    // A writeback in the same cycle clears the old writer, so no hazard.
    assign waw_hit = iss_ok && pend[bus.iss_addr] &&
                     !(bus.wb_en && bus.wb_addr == bus.iss_addr);

    assign bus.pend_cnt = cnt_q;
    assign bus.err_waw  = err_q;

    // Read ports: zero reg, then MEM forward, then WB, then array.
    always_comb begin
        logic [AW-1:0] a;
        logic          zhit;
        logic          fhit;
        logic          whit;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            a    = bus.rd_addr[p*AW +: AW];
            zhit = ZR && (a == '0);
            fhit = bus.fwd_en && (bus.fwd_addr == a);
            whit = bus.wb_en && (bus.wb_addr == a);
            if (zhit)
                bus.rd_data[p*DW +: DW] = '0;
            else if (fhit)
                bus.rd_data[p*DW +: DW] = bus.fwd_data;
            else if (whit)
                bus.rd_data[p*DW +: DW] = bus.wb_data;
            else
                bus.rd_data[p*DW +: DW] = mem[a];
            bus.rd_busy[p] = pend[a] && !fhit && !whit && !zhit;
        end
    end

    // Next pending vector: writeback clears, issue sets and wins.
    always_comb begin
        pend_nxt = pend;
        if (bus.wb_en)
            pend_nxt[bus.wb_addr] = 1'b0;
        if (iss_ok)
            pend_nxt[bus.iss_addr] = 1'b1;
    end

    // Population count of the updated pending vector.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
    end

    // Register array, cleared as a whole on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wb_ok) begin
            mem[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Scoreboard, its count and the sticky WAW flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pend  <= pend_nxt;
            cnt_q <= cnt_nxt;
            if (waw_hit)
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Self-checking bench for regfile_fwd_sb: reference model feeds a
// scoreboard queue of expected outputs compared mid-cycle.
module tb_regfile_fwd_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NRD = 2;

    typedef struct {
        string       tag;
        logic [63:0] v;
    } exp_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    exp_t exp_q[$];

    logic [31:0] m_mem [32];
    logic [31:0] m_pend;
    logic        m_err;

    regfile_fwd_sb_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

    regfile_fwd_sb #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (bus.fwd_en && bus.fwd_addr == a) return bus.fwd_data;
        if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (bus.fwd_en && bus.fwd_addr == a) return 1'b0;
        if (bus.wb_en && bus.wb_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        m_pend = 32'h0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge();
        logic iss_ok;
        if (reset) return;
        iss_ok = bus.iss_en && bus.iss_addr != 5'd0;
        if (iss_ok && m_pend[bus.iss_addr] &&
            !(bus.wb_en && bus.wb_addr == bus.iss_addr))
            m_err = 1'b1;
        if (bus.wb_en && bus.wb_addr != 5'd0)
            m_mem[bus.wb_addr] = bus.wb_data;
        if (bus.wb_en) m_pend[bus.wb_addr] = 1'b0;
        if (iss_ok) m_pend[bus.iss_addr] = 1'b1;
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_all();
        logic [4:0] a0;
        logic [4:0] a1;
        a0 = bus.rd_addr[4:0];
        a1 = bus.rd_addr[9:5];
        push("rd_data0", 64'(m_rd(a0)));
        push("rd_data1", 64'(m_rd(a1)));
        push("rd_busy", 64'({m_busy(a1), m_busy(a0)}));
        push("pend_cnt", 64'($countones(m_pend)));
        push("err_waw", 64'(m_err));
    endtask

    task automatic compare_all();
        logic [63:0] obs [5];
        exp_t e;
        obs[0] = 64'(bus.rd_data[31:0]);
        obs[1] = 64'(bus.rd_data[63:32]);
        obs[2] = 64'(bus.rd_busy);
        obs[3] = 64'(bus.pend_cnt);
        obs[4] = 64'(bus.err_waw);
        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'd0, 64'd1);
            end else begin
                e = exp_q.pop_front();
                check(e.tag, obs[i], e.v);
            end
        end
    endtask

    task automatic observe();
        #1;
        expect_all();
        #1;
        compare_all();
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_en  = 1'b0;
        bus.fwd_en = 1'b0;
        bus.iss_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_en   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    task automatic fwd(input logic [4:0] a, input logic [31:0] d);
        bus.fwd_en   = 1'b1;
        bus.fwd_addr = a;
        bus.fwd_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        bus.iss_en   = 1'b1;
        bus.iss_addr = a;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        bus.rd_addr  = '0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.fwd_addr = '0;
        bus.fwd_data = '0;
        bus.iss_addr = '0;
        idle();
        model_reset();

        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a));
            observe();
        end
        check("rst_cnt", 64'(bus.pend_cnt), 64'd0);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        rd(5'd5, 5'd0);
        wb(5'd5, 32'hDEADBEEF);
        observe();
        check("wb_bypass", 64'(bus.rd_data[31:0]), 64'hDEADBEEF);
        advance();
        idle();
        observe();
        check("wb_stored", 64'(bus.rd_data[31:0]), 64'hDEADBEEF);
        wb(5'd0, 32'h12345678);
        observe();
        advance();
        idle();
        observe();
        check("zero_reg", 64'(bus.rd_data[63:32]), 64'd0);

        wb(5'd7, 32'h11);
        advance();
        rd(5'd5, 5'd7);
        wb(5'd7, 32'h22);
        fwd(5'd7, 32'h33);
        observe();
        check("fwd_prio", 64'(bus.rd_data[63:32]), 64'h33);
        bus.fwd_en = 1'b0;
        observe();
        check("wb_prio", 64'(bus.rd_data[63:32]), 64'h22);
        advance();
        idle();

        iss(5'd9);
        advance();
        idle();
        rd(5'd9, 5'd7);
        observe();
        check("busy9", 64'(bus.rd_busy[0]), 64'd1);
        check("cnt1", 64'(bus.pend_cnt), 64'd1);
        fwd(5'd9, 32'h55);
        observe();
        check("fwd_unbusy", 64'(bus.rd_busy[0]), 64'd0);
        idle();
        wb(5'd9, 32'h44);
        advance();
        idle();
        observe();
        check("wb9_data", 64'(bus.rd_data[31:0]), 64'h44);
        check("cnt0", 64'(bus.pend_cnt), 64'd0);

        iss(5'd3);
        advance();
        iss(5'd3);
        wb(5'd3, 32'h66);
        advance();
        idle();
        rd(5'd3, 5'd3);
        observe();
        check("iss_wb_busy", 64'(bus.rd_busy), 64'd3);
        check("no_waw", 64'(bus.err_waw), 64'd0);
        iss(5'd3);
        advance();
        idle();
        observe();
        check("waw_set", 64'(bus.err_waw), 64'd1);
        wb(5'd3, 32'h77);
        advance();
        idle();
        observe();
        check("waw_sticky", 64'(bus.err_waw), 64'd1);

        for (int i = 1; i <= 4; i++) begin
            iss(5'(i));
            wb(5'(i + 9), 32'hA000_0000 + 32'(i));
            advance();
        end
        idle();
        rd(5'd11, 5'd2);
        observe();
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_async_cnt", 64'(bus.pend_cnt), 64'd0);
        check("rst_async_err", 64'(bus.err_waw), 64'd0);
        check("rst_async_rd", 64'(bus.rd_data), 64'd0);
        observe();
        wb(5'd12, 32'hBAD);
        iss(5'd12);
        advance();
        idle();
        rd(5'd12, 5'd12);
        observe();
        check("rst_dom", 64'(bus.rd_data), 64'd0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 300; n++) begin
            idle();
            rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if ($urandom_range(0, 2) == 0) wb(5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 3) == 0) fwd(5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) == 0) iss(5'($urandom_range(0, 7)));
            observe();
            advance();
        end
        idle();
        observe();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
